// File: rtl/if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg -- fetch/decode pipeline register for a MIPS-style 5-stage core.
//
// Captures the instruction, PC and fetch exception code coming out of the
// fetch stage. Along with that state it tracks two flags:
//   - whether the captured instruction sits in a branch delay slot
//   - whether it is a real fetched instruction or a bubble
//
// Update priority on each rising clock edge: Reset > flush > stall > load.
//
// Parameters
//   RESET_PC   PC value presented in decode after reset
//   NO_EXC     exception code meaning "no exception"
//
// Ports
//   clk        single clock, all state updates on its rising edge
//   Reset      synchronous active-high reset
//   instr_F    instruction word from fetch (0 when fetch faulted)
//   PC_F       fetch-stage PC
//   exc_F      fetch-stage exception code (NO_EXC or AdEL)
//   stall_D    hazard unit holds the decode stage
//   if_handler exception/interrupt taken, flush decode
//   if_eret    eret redirect, flush decode
//   is_jump_D  instruction currently in decode is a branch/jump
//   instr_D    registered instruction for decode
//   PC_D       registered PC
//   PC8_D      PC_D + 8 (link address), combinational from PC_D
//   exc_D      registered exception code
//   bd_D       instr_D sits in a branch delay slot
//   valid_D    instr_D is a real fetched instruction, not a bubble
// ----------------------------------------------------------------------------
module if_id_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [4:0]  NO_EXC   = 5'd0
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [31:0] instr_F,
    input  logic [31:0] PC_F,
    input  logic [4:0]  exc_F,
    input  logic        stall_D,
    input  logic        if_handler,
    input  logic        if_eret,
    input  logic        is_jump_D,
    output logic [31:0] instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC8_D,
    output logic [4:0]  exc_D,
    output logic        bd_D,
    output logic        valid_D
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q,    pc_d;
    logic [4:0]  exc_q,   exc_d;
    logic        bd_q,    bd_d;
    logic        valid_q, valid_d;

    logic flush;

    assign flush = if_handler | if_eret;

    // Next-state selection. Reset is applied in the sequential block; this
    // block resolves flush > stall > load.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        exc_d   = exc_q;
        bd_d    = bd_q;
        valid_d = valid_q;

        if (flush) begin
            // Insert a bubble but keep the redirected PC so CP0/EPC logic
            // downstream still sees where the pipeline resumed.
            instr_d = 32'd0;
            pc_d    = PC_F;
            exc_d   = NO_EXC;
            bd_d    = 1'b0;
            valid_d = 1'b0;
        end else if (!stall_D) begin
            // A faulted fetch carries no usable opcode; zero it (a nop) but
            // keep it valid so the exception code reaches CP0.
            instr_d = (exc_F != NO_EXC) ? 32'd0 : instr_F;
            pc_d    = PC_F;
            exc_d   = exc_F;
            // The branch still in decode marks the slot being loaded behind it.
            bd_d    = is_jump_D;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            instr_q <= 32'd0;
            pc_q    <= RESET_PC;
            exc_q   <= NO_EXC;
            bd_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            exc_q   <= exc_d;
            bd_q    <= bd_d;
            valid_q <= valid_d;
        end
    end

    assign instr_D = instr_q;
    assign PC_D    = pc_q;
    assign PC8_D   = pc_q + 32'd8;  // wraps modulo 2^32
    assign exc_D   = exc_q;
    assign bd_D    = bd_q;
    assign valid_D = valid_q;

endmodule

// File: tb/tb_if_id_reg.sv
module tb_if_id_reg;

    logic        clk = 1'b0;
    logic        Reset;
    logic [31:0] instr_F;
    logic [31:0] PC_F;
    logic [4:0]  exc_F;
    logic        stall_D;
    logic        if_handler;
    logic        if_eret;
    logic        is_jump_D;
    logic [31:0] instr_D;
    logic [31:0] PC_D;
    logic [31:0] PC8_D;
    logic [4:0]  exc_D;
    logic        bd_D;
    logic        valid_D;

    always #5 clk = ~clk;

    if_id_reg dut (
        .clk        (clk),
        .Reset      (Reset),
        .instr_F    (instr_F),
        .PC_F       (PC_F),
        .exc_F      (exc_F),
        .stall_D    (stall_D),
        .if_handler (if_handler),
        .if_eret    (if_eret),
        .is_jump_D  (is_jump_D),
        .instr_D    (instr_D),
        .PC_D       (PC_D),
        .PC8_D      (PC8_D),
        .exc_D      (exc_D),
        .bd_D       (bd_D),
        .valid_D    (valid_D)
    );

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic [4:0]  exc;
        logic        bd;
        logic        valid;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   stim_done   = 1'b0;

    // Drive one cycle of inputs on the falling edge and queue the
    // hand-computed decode state expected after the next rising edge.
    task automatic apply(
        input string       name,
        input logic        rst,
        input logic        stall,
        input logic        hnd,
        input logic        eret,
        input logic        jmp,
        input logic [31:0] ins,
        input logic [31:0] pc,
        input logic [4:0]  exc,
        input logic [31:0] e_instr,
        input logic [31:0] e_pc,
        input logic [31:0] e_pc8,
        input logic [4:0]  e_exc,
        input logic        e_bd,
        input logic        e_valid
    );
        exp_t e;
        @(negedge clk);
        Reset      = rst;
        stall_D    = stall;
        if_handler = hnd;
        if_eret    = eret;
        is_jump_D  = jmp;
        instr_F    = ins;
        PC_F       = pc;
        exc_F      = exc;
        e.name  = name;
        e.instr = e_instr;
        e.pc    = e_pc;
        e.pc8   = e_pc8;
        e.exc   = e_exc;
        e.bd    = e_bd;
        e.valid = e_valid;
        exp_q.push_back(e);
    endtask

    // Monitor: every rising edge the register presents a new decode state;
    // compare it against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (instr_D !== e.instr || PC_D !== e.pc || PC8_D !== e.pc8 ||
                    exc_D !== e.exc || bd_D !== e.bd || valid_D !== e.valid) begin
                    miscompares++;
                    $display("FAIL %s: got instr=%h pc=%h pc8=%h exc=%0d bd=%b valid=%b, want instr=%h pc=%h pc8=%h exc=%0d bd=%b valid=%b",
                             e.name, instr_D, PC_D, PC8_D, exc_D, bd_D, valid_D,
                             e.instr, e.pc, e.pc8, e.exc, e.bd, e.valid);
                end else begin
                    $display("ok   %s: instr=%h pc=%h pc8=%h exc=%0d bd=%b valid=%b",
                             e.name, instr_D, PC_D, PC8_D, exc_D, bd_D, valid_D);
                end
            end
        end
    end

    initial begin
        Reset = 1'b1; stall_D = 1'b0; if_handler = 1'b0; if_eret = 1'b0;
        is_jump_D = 1'b0; instr_F = 32'hDEAD_BEEF; PC_F = 32'h1234_5678; exc_F = 5'd0;

        //     name          rst stl hnd ert jmp instr_F       PC_F          exc   | instr_D       PC_D          PC8_D         exc bd valid
        apply("reset_1",     1,  0,  0,  0,  1,  32'hDEAD_BEEF, 32'h1234_5678, 5'd4, 32'h0,         32'h0000_3000, 32'h0000_3008, 5'd0, 0, 0);
        apply("reset_2",     1,  1,  1,  0,  1,  32'hCAFE_F00D, 32'h0000_4000, 5'd0, 32'h0,         32'h0000_3000, 32'h0000_3008, 5'd0, 0, 0);
        apply("load_lui",    0,  0,  0,  0,  0,  32'h3C01_1234, 32'h0000_3004, 5'd0, 32'h3C01_1234, 32'h0000_3004, 32'h0000_300C, 5'd0, 0, 1);
        apply("stall_1",     0,  1,  0,  0,  1,  32'h1111_1111, 32'h0000_3008, 5'd0, 32'h3C01_1234, 32'h0000_3004, 32'h0000_300C, 5'd0, 0, 1);
        apply("stall_2",     0,  1,  0,  0,  1,  32'h2222_2222, 32'h0000_3008, 5'd4, 32'h3C01_1234, 32'h0000_3004, 32'h0000_300C, 5'd0, 0, 1);
        apply("stall_3",     0,  1,  0,  0,  0,  32'h3333_3333, 32'h0000_3008, 5'd0, 32'h3C01_1234, 32'h0000_3004, 32'h0000_300C, 5'd0, 0, 1);
        apply("unstall",     0,  0,  0,  0,  0,  32'h2442_0001, 32'h0000_3008, 5'd0, 32'h2442_0001, 32'h0000_3008, 32'h0000_3010, 5'd0, 0, 1);
        apply("load_beq",    0,  0,  0,  0,  0,  32'h1022_0003, 32'h0000_300C, 5'd0, 32'h1022_0003, 32'h0000_300C, 32'h0000_3014, 5'd0, 0, 1);
        apply("delay_slot",  0,  0,  0,  0,  1,  32'h0022_1820, 32'h0000_3010, 5'd0, 32'h0022_1820, 32'h0000_3010, 32'h0000_3018, 5'd0, 1, 1);
        apply("after_slot",  0,  0,  0,  0,  0,  32'h8C41_0000, 32'h0000_3014, 5'd0, 32'h8C41_0000, 32'h0000_3014, 32'h0000_301C, 5'd0, 0, 1);
        apply("stall_flush", 0,  1,  1,  0,  1,  32'h5555_5555, 32'h0000_4180, 5'd0, 32'h0,         32'h0000_4180, 32'h0000_4188, 5'd0, 0, 0);
        apply("eret_flush",  0,  0,  0,  1,  1,  32'hFFFF_FFFF, 32'h0000_3018, 5'd4, 32'h0,         32'h0000_3018, 32'h0000_3020, 5'd0, 0, 0);
        apply("adel_load",   0,  0,  0,  0,  0,  32'hFFFF_FFFF, 32'h0000_3002, 5'd4, 32'h0,         32'h0000_3002, 32'h0000_300A, 5'd4, 0, 1);
        apply("pc8_wrap",    0,  0,  0,  0,  0,  32'h1234_5678, 32'hFFFF_FFFC, 5'd0, 32'h1234_5678, 32'hFFFF_FFFC, 32'h0000_0004, 5'd0, 0, 1);
        apply("pc8_zero",    0,  0,  0,  0,  0,  32'h0000_0000, 32'hFFFF_FFF8, 5'd0, 32'h0000_0000, 32'hFFFF_FFF8, 32'h0000_0000, 5'd0, 0, 1);
        apply("jump_load",   0,  0,  0,  0,  1,  32'hAAAA_AAAA, 32'h0000_3020, 5'd0, 32'hAAAA_AAAA, 32'h0000_3020, 32'h0000_3028, 5'd0, 1, 1);
        apply("rst_in_stall",1,  1,  0,  0,  1,  32'hBBBB_BBBB, 32'h0000_3024, 5'd4, 32'h0,         32'h0000_3000, 32'h0000_3008, 5'd0, 0, 0);
        apply("post_reset",  0,  0,  0,  0,  0,  32'h3C01_1234, 32'h0000_3000, 5'd0, 32'h3C01_1234, 32'h0000_3000, 32'h0000_3008, 5'd0, 0, 1);
        stim_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        wait (stim_done);
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
